tb_mem_port_arbiter: RTL and testbench
======================================

# tb_mem_port_arbiter

Two-requester OBI-style arbiter that shares one memory port between the core's instruction fetch interface and its data interface. It sits between the core wrapper and a single-ported memory model in the verification subsystem. It is used to exercise the core against realistic fetch/load contention, instead of the dual-ported RAM path. It arbitrates requests, holds a selection stable until granted, and tracks outstanding transactions in order so that each response returns to the requester that issued it.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, read/write data width
- MAX_OUTSTANDING, 2, depth of the in-order response-ID FIFO (1..8)
- FIXED_PRIO, 0, 0 = round-robin; 1 = data port always wins conflicts

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- instr_req_i  in  1  instruction request (read-only port 0)
- instr_addr_i  in  ADDR_WIDTH  instruction address
- instr_gnt_o  out  1  instruction request accepted
- instr_rvalid_o  out  1  instruction response valid
- instr_rdata_o  out  DATA_WIDTH  instruction read data
- data_req_i  in  1  data request (port 1)
- data_addr_i  in  ADDR_WIDTH  data address
- data_we_i  in  1  write enable
- data_be_i  in  DATA_WIDTH/8  byte enables
- data_wdata_i  in  DATA_WIDTH  write data
- data_gnt_o  out  1  data request accepted
- data_rvalid_o  out  1  data response valid (reads and writes)
- data_rdata_o  out  DATA_WIDTH  data read data
- mem_req_o  out  1  request to memory
- mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o  out  as above  muxed request fields; instr selection drives we=0, be=all ones, wdata=0
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid, in issue order
- mem_rdata_i  in  DATA_WIDTH  memory read data
- busy_o  out  1  one or more transactions outstanding
- err_o  out  1  sticky: mem_rvalid_i seen with empty ID FIFO

## Operation
- States: ARB and HOLD.
  - ARB: select a requester combinationally.
  - ARB -> HOLD: mem_req_o=1 and mem_gnt_i=0. The selected port is latched in sel_q.
  - HOLD: the latched port stays selected regardless of the other request.
  - HOLD -> ARB: on mem_gnt_i.
- Selection in ARB:
  - Only one port requesting: select it.
  - Both requesting, FIXED_PRIO=0: select the port not in last_q.
  - Both requesting, FIXED_PRIO=1: select the data port.
- last_q updates to the selected port on every memory handshake (mem_req_o & mem_gnt_i).
- Issue gating: mem_req_o = (selected port requesting) & (count < MAX_OUTSTANDING).
  - When the FIFO is full, no request is issued, even if a pop occurs in the same cycle.
  - A held selection stays held while full.
- Grant: <port>_gnt_o = mem_gnt_i & mem_req_o & (selected == port). Never both grants in one cycle.
- ID FIFO:
  - Push the selected port ID on handshake.
  - Pop on mem_rvalid_i.
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Response routing:
  - rdata_o of both ports = mem_rdata_i (broadcast).
  - rvalid_o goes only to the port at the FIFO head.
  - mem_rvalid_i with an empty FIFO: no port rvalid, err_o set until reset.
- busy_o = (count != 0).
- A requester dropping req before gnt is a protocol violation. Behaviour is undefined; the arbiter does not check it.

## Timing
- Reset values: state=ARB, sel_q=instr, last_q=data (instr wins the first conflict), count=0, pointers=0, err_o=0. All gnt/rvalid outputs and mem_req_o are 0 while rst_i is high.
- Zero-cycle paths:
  - request -> mem_req_o / mem_* fields.
  - mem_gnt_i -> port gnt.
  - mem_rvalid_i -> port rvalid.
  - No added latency.
- The arbiter adds no bubbles. Back-to-back handshakes from alternating ports are possible every cycle, up to MAX_OUTSTANDING in flight.
- Reset mid-operation: FIFO is flushed and state returns to ARB. Responses arriving after reset release are treated as spurious (err_o set).

## Test plan
- Single instr read, mem gnt same cycle, rvalid next cycle with rdata=0xDEADBEEF -> instr_gnt_o=1 in cycle 0, instr_rvalid_o=1 and instr_rdata_o=0xDEADBEEF in cycle 1, data_rvalid_o=0 throughout.
- Both ports request continuously, FIXED_PRIO=0, mem_gnt_i=1 always, rvalid 1 cycle later -> grants alternate instr, data, instr, data... starting with instr; each rvalid goes to the matching port.
- Data write (we=1, be=4'b0011, wdata=0x12345678) competing with instr, mem_gnt_i low for 3 cycles -> selection latched: mem_addr_o/mem_wdata_o stable all 3 cycles, instr not granted until after the data handshake.
- MAX_OUTSTANDING=2, mem_gnt_i=1, rvalid withheld -> exactly 2 handshakes, then mem_req_o=0 and busy_o=1. Two rvalids are returned in issue order; the next issue occurs only in the cycle after count drops below 2.
- mem_rvalid_i pulse with no outstanding transaction -> no port rvalid, err_o=1 and stays 1 until rst_i.
- Assert rst_i with 2 outstanding -> count=0, busy_o=0, mem_req_o=0 during reset; a later stray rvalid sets err_o.

Source files
------------

// File: rtl/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Shares one OBI-style memory port between an instruction-fetch port (read-only,
// port 0) and a data port (port 1). Requests are arbitrated combinationally; a
// selection that is presented but not yet granted is latched until the memory
// accepts it. Issued transactions are tracked in an in-order ID FIFO so that
// each response is routed back to the port that issued it.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   instr_req/addr/gnt/rvalid/rdata   instruction port (read-only)
//   data_req/addr/we/be/wdata/gnt/rvalid/rdata   data port
//   mem_req/addr/we/be/wdata/gnt/rvalid/rdata    shared memory port
//   busy_o                       at least one transaction outstanding
//   err_o                        sticky: response seen with nothing outstanding
//
// State   | Meaning
// --------+--------------------------------------------------------------
// ST_ARB  | selection computed each cycle from the live requests
// ST_HOLD | request presented but not granted; sel_q stays selected
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int FIXED_PRIO      = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic PORT_INSTR = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    typedef enum logic {ST_ARB, ST_HOLD} state_e;

    state_e                     state_q, state_d;
    logic                       sel_q, sel_d;
    logic                       last_q, last_d;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       err_q, err_d;

    logic sel;
    logic sel_req;
    logic full;
    logic empty;
    logic handshake;
    logic pop;
    logic head_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Arbitration, issue gating and response routing (all zero-cycle paths).
    always_comb begin
        sel = sel_q;
        if (state_q == ST_ARB) begin
            if (instr_req_i && data_req_i) begin
                sel = (FIXED_PRIO != 0) ? PORT_DATA : ~last_q;
            end else if (data_req_i) begin
                sel = PORT_DATA;
            end else begin
                sel = PORT_INSTR;
            end
        end

        sel_req = sel ? data_req_i : instr_req_i;
        full    = (count_q == CNT_W'(MAX_OUTSTANDING));
        empty   = (count_q == '0);

        // A pop in the same cycle does not free a slot for issue: gating uses
        // the registered count only, which keeps mem_req_o off the rvalid path.
        mem_req_o   = sel_req & ~full & ~rst_i;
        handshake   = mem_req_o & mem_gnt_i;
        pop         = mem_rvalid_i & ~empty & ~rst_i;
        head_id     = id_q[rd_ptr_q];

        mem_addr_o  = sel ? data_addr_i : instr_addr_i;
        mem_we_o    = sel & data_we_i;
        mem_be_o    = sel ? data_be_i : '1;
        mem_wdata_o = sel ? data_wdata_i : '0;

        instr_gnt_o    = handshake & (sel == PORT_INSTR);
        data_gnt_o     = handshake & (sel == PORT_DATA);
        instr_rvalid_o = pop & (head_id == PORT_INSTR);
        data_rvalid_o  = pop & (head_id == PORT_DATA);
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;

        busy_o = ~empty;
        err_o  = err_q;
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;

        case (state_q)
            ST_ARB: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_d = ST_HOLD;
                    sel_d   = sel;
                end
            end
            ST_HOLD: begin
                if (handshake) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase

        if (handshake) begin
            last_d       = sel;
            id_d[wr_ptr_q] = sel;
            wr_ptr_d     = ptr_inc(wr_ptr_q);
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({handshake, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (mem_rvalid_i && empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_ARB;
            sel_q    <= PORT_INSTR;
            last_q   <= PORT_DATA;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            id_q     <= id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for tb_mem_port_arbiter (MAX_OUTSTANDING=2, round-robin).
// A queue-based reference model tracks outstanding port IDs, the last winner
// and any pending (presented but ungranted) selection, and predicts every
// output each cycle. Directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAX = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          instr_req_i = 1'b0;
    logic [AW-1:0] instr_addr_i = '0;
    logic          instr_gnt_o, instr_rvalid_o;
    logic [DW-1:0] instr_rdata_o;
    logic          data_req_i = 1'b0;
    logic [AW-1:0] data_addr_i = '0;
    logic          data_we_i = 1'b0;
    logic [3:0]    data_be_i = '0;
    logic [DW-1:0] data_wdata_i = '0;
    logic          data_gnt_o, data_rvalid_o;
    logic [DW-1:0] data_rdata_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          busy_o, err_o;

    tb_mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX), .FIXED_PRIO(0)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec  = 0;
    int n_miss = 0;

    // reference model state
    int q_ids[$];        // outstanding port IDs in issue order (0 instr, 1 data)
    int gnt_log[$];      // port of every handshake, for sequence checks
    bit last_m     = 1'b1;
    bit hold_m     = 1'b0;
    bit hold_sel_m = 1'b0;
    bit err_m      = 1'b0;
    bit igr_m, dgr_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Predict and compare this cycle's outputs, then advance the model as the
    // rising edge will. Called mid low-phase, inputs already stable.
    task automatic sample();
        int n;
        bit s, sreq, er, hs, ev;
        #1;
        igr_m = 1'b0;
        dgr_m = 1'b0;
        if (rst_i) begin
            chk("rst_mem_req", mem_req_o, 0);
            chk("rst_igrant",  instr_gnt_o, 0);
            chk("rst_dgrant",  data_gnt_o, 0);
            chk("rst_irvalid", instr_rvalid_o, 0);
            chk("rst_drvalid", data_rvalid_o, 0);
            chk("rst_busy",    busy_o, 0);
            chk("rst_err",     err_o, 0);
            q_ids.delete();
            last_m = 1'b1;
            hold_m = 1'b0;
            err_m  = 1'b0;
            return;
        end
        n = q_ids.size();
        if (hold_m)                        s = hold_sel_m;
        else if (instr_req_i && data_req_i) s = ~last_m;
        else                               s = data_req_i;
        sreq = s ? data_req_i : instr_req_i;
        er   = sreq && (n < MAX);
        hs   = er && mem_gnt_i;
        ev   = mem_rvalid_i && (n > 0);

        chk("mem_req", mem_req_o, er);
        chk("igrant",  instr_gnt_o, hs && !s);
        chk("dgrant",  data_gnt_o, hs && s);
        chk("irvalid", instr_rvalid_o, ev && q_ids[0] == 0);
        chk("drvalid", data_rvalid_o, ev && q_ids[0] == 1);
        chk("irdata",  instr_rdata_o, mem_rdata_i);
        chk("drdata",  data_rdata_o, mem_rdata_i);
        chk("busy",    busy_o, n != 0);
        chk("err",     err_o, err_m);
        if (er) begin
            chk("mem_addr",  mem_addr_o, s ? data_addr_i : instr_addr_i);
            chk("mem_we",    mem_we_o, s ? data_we_i : 1'b0);
            chk("mem_be",    mem_be_o, s ? data_be_i : 4'hF);
            chk("mem_wdata", mem_wdata_o, s ? data_wdata_i : 32'h0);
        end

        if (mem_rvalid_i && n == 0) err_m = 1'b1;
        if (ev) void'(q_ids.pop_front());
        if (hs) begin
            q_ids.push_back(int'(s));
            gnt_log.push_back(int'(s));
            last_m = s;
            hold_m = 1'b0;
        end else if (er) begin
            hold_m     = 1'b1;
            hold_sel_m = s;
        end
        igr_m = hs && !s;
        dgr_m = hs && s;
    endtask

    task automatic step();
        sample();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        instr_req_i  = 1'b0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    task automatic drain();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        mem_gnt_i   = 1'b0;
        for (int k = 0; k < MAX + 2 && q_ids.size() > 0; k++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom;
            step();
        end
        mem_rvalid_i = 1'b0;
    endtask

    task automatic rand_traffic(input int cycles, input bit allow_spurious);
        bit ip = 1'b0, dp = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (!ip && $urandom_range(0, 99) < 55) begin
                ip = 1'b1;
                instr_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!dp && $urandom_range(0, 99) < 55) begin
                dp = 1'b1;
                data_addr_i  = $urandom;
                data_we_i    = $urandom_range(0, 1);
                data_be_i    = 4'($urandom_range(0, 15));
                data_wdata_i = $urandom;
            end
            instr_req_i  = ip;
            data_req_i   = dp;
            mem_gnt_i    = ($urandom_range(0, 99) < 65);
            mem_rvalid_i = (q_ids.size() > 0 || allow_spurious) && ($urandom_range(0, 99) < 45);
            mem_rdata_i  = $urandom;
            step();
            if (igr_m) ip = 1'b0;
            if (dgr_m) dp = 1'b0;
        end
        drain();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk_i);
        step();
        step();
        rst_i = 1'b0;
        step();

        // single instruction read
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0100;
        mem_gnt_i    = 1'b1;
        sample();
        chk("t1_igrant", instr_gnt_o, 1);
        @(negedge clk_i);
        instr_req_i  = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        sample();
        chk("t1_irvalid", instr_rvalid_o, 1);
        chk("t1_irdata", instr_rdata_o, 32'hDEAD_BEEF);
        chk("t1_drvalid", data_rvalid_o, 0);
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        step();

        // continuous contention: grants alternate starting with instr
        do_reset();
        gnt_log.delete();
        instr_req_i  = 1'b1;
        data_req_i   = 1'b1;
        instr_addr_i = 32'h0000_0200;
        data_addr_i  = 32'h0000_1000;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        mem_gnt_i    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_rvalid_i = (i > 0);
            mem_rdata_i  = $urandom;
            step();
        end
        for (int i = 0; i < 8; i++) begin
            chk("t2_order", (i < gnt_log.size()) ? gnt_log[i] : -1, i % 2);
        end
        drain();

        // data write held under a stalled memory (last winner = instr)
        instr_req_i = 1'b1;
        mem_gnt_i   = 1'b1;
        step();
        drain();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0300;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h0000_2000;
        data_we_i    = 1'b1;
        data_be_i    = 4'b0011;
        data_wdata_i = 32'h1234_5678;
        mem_gnt_i    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t3_addr", mem_addr_o, 32'h0000_2000);
            chk("t3_wdata", mem_wdata_o, 32'h1234_5678);
            chk("t3_igrant", instr_gnt_o, 0);
            @(negedge clk_i);
        end
        mem_gnt_i = 1'b1;
        sample();
        chk("t3_dgrant", data_gnt_o, 1);
        @(negedge clk_i);
        data_req_i = 1'b0;
        step();
        drain();

        // outstanding limit
        instr_req_i = 1'b1;
        mem_gnt_i   = 1'b1;
        step();
        step();
        sample();
        chk("t4_req_full", mem_req_o, 0);
        chk("t4_busy", busy_o, 1);
        @(negedge clk_i);
        mem_rvalid_i = 1'b1;
        sample();
        chk("t4_req_popcycle", mem_req_o, 0);
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        sample();
        chk("t4_req_after", mem_req_o, 1);
        @(negedge clk_i);
        drain();

        // spurious response
        idle_inputs();
        mem_rvalid_i = 1'b1;
        sample();
        chk("t5_irvalid", instr_rvalid_o, 0);
        chk("t5_drvalid", data_rvalid_o, 0);
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) step();
        sample();
        chk("t5_err_sticky", err_o, 1);
        @(negedge clk_i);

        // reset with two outstanding, then a stray response
        do_reset();
        instr_req_i = 1'b1;
        mem_gnt_i   = 1'b1;
        step();
        step();
        rst_i = 1'b1;
        sample();
        chk("t6_req_rst", mem_req_o, 0);
        chk("t6_busy_rst", busy_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_inputs();
        step();
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        sample();
        chk("t6_err", err_o, 1);
        @(negedge clk_i);

        // randomized traffic, then with occasional spurious responses
        do_reset();
        rand_traffic(3000, 1'b0);
        do_reset();
        rand_traffic(400, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
